// File: rtl/bp_pkg.sv
// Shared constants and types for the branch predictor: counter states, BTB entry layout, default sizes.
package bp_pkg;

    localparam int BTB_ENTRIES_DEF = 32;
    localparam int BHT_ENTRIES_DEF = 128;
    localparam int CNT_W_DEF       = 2;
    localparam int GHR_W_DEF       = 7;

    // 2-bit counter encodings; wider counters keep 0 as strongly not-taken
    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
    } btb_entry_t;

endpackage

// File: rtl/bp_counter_table.sv
// Purpose: table of saturating taken/not-taken counters with one read and one write port.
// Latency: read is combinational (pre-write contents); write lands on the rising edge.
// Backpressure: none, one update accepted every cycle; async active-low clear.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int ENTRIES = BHT_ENTRIES_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int IW     = $clog2(ENTRIES)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [IW-1:0]    rd_idx,
    output logic [CNT_W-1:0] rd_cnt,
    input  logic             wr_vld,
    input  logic [IW-1:0]    wr_idx,
    input  logic             wr_taken
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(STRONG_NT);

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] wr_cur;
    logic [CNT_W-1:0] wr_nxt;

    assign rd_cnt = cnt_q[rd_idx];
    assign wr_cur = cnt_q[wr_idx];

    always_comb begin
        wr_nxt = wr_cur;
        if (wr_taken && wr_cur != CNT_MAX)
            wr_nxt = wr_cur + CNT_W'(1);
        else if (!wr_taken && wr_cur != CNT_ZERO)
            wr_nxt = wr_cur - CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < ENTRIES; i++)
                cnt_q[i] <= CNT_ZERO;
        end else if (wr_vld) begin
            cnt_q[wr_idx] <= wr_nxt;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Purpose: BTB + saturating-counter BHT branch predictor with execute-stage redirect; GSHARE_EN adds global-history indexing.
// Latency: fetch lookup and Mispredict/PCCorrect are combinational; tables and MispredCount update on the rising edge.
// Backpressure: none, one lookup and one resolution per cycle; async active-low reset clears valid/counter/history state.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = BTB_ENTRIES_DEF,
    parameter int BHT_ENTRIES = BHT_ENTRIES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int GHR_W       = GHR_W_DEF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] PC_current,
    input  logic [31:0] PC,
    input  logic [31:0] PCBranch,
    input  logic        Branch,
    input  logic        BranchTaken,
    input  logic        PredictedE,
    input  logic [31:0] PredTargetE,
    output logic [31:0] PCPredict,
    output logic        Prediction,
    output logic        Mispredict,
    output logic [31:0] PCCorrect,
    output logic [31:0] MispredCount
);

    localparam int BTB_IW = $clog2(BTB_ENTRIES);
    localparam int BHT_IW = $clog2(BHT_ENTRIES);

    logic              btb_vld_q [BTB_ENTRIES];
    logic [31:0]       btb_tag_q [BTB_ENTRIES];
    logic [31:0]       btb_tgt_q [BTB_ENTRIES];
    logic [BTB_IW-1:0] lk_btb_idx;
    logic [BTB_IW-1:0] up_btb_idx;
    btb_entry_t        lk_entry;
    logic              btb_hit;

    logic [BHT_IW-1:0] lk_bht_idx;
    logic [BHT_IW-1:0] up_bht_idx;
    logic [CNT_W-1:0]  lk_cnt;
    logic              btb_wr;

    assign lk_btb_idx = PC_current[BTB_IW+1:2];
    assign up_btb_idx = PC[BTB_IW+1:2];
    assign btb_wr     = Branch && BranchTaken;

`ifdef GSHARE_EN
    logic [GHR_W-1:0] ghr_q;

    // Update uses the history as it stood before this branch shifts in.
    assign lk_bht_idx = PC_current[BHT_IW+1:2] ^ BHT_IW'(ghr_q);
    assign up_bht_idx = PC[BHT_IW+1:2] ^ BHT_IW'(ghr_q);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            ghr_q <= '0;
        else if (Branch)
            ghr_q <= (ghr_q << 1) | GHR_W'(BranchTaken);
    end
`else
    assign lk_bht_idx = PC_current[BHT_IW+1:2];
    assign up_bht_idx = PC[BHT_IW+1:2];
`endif

    bp_counter_table #(
        .ENTRIES (BHT_ENTRIES),
        .CNT_W   (CNT_W)
    ) u_bht (
        .Clk      (Clk),
        .Rst      (Rst),
        .rd_idx   (lk_bht_idx),
        .rd_cnt   (lk_cnt),
        .wr_vld   (Branch),
        .wr_idx   (up_bht_idx),
        .wr_taken (BranchTaken)
    );

    assign lk_entry.valid  = btb_vld_q[lk_btb_idx];
    assign lk_entry.tag    = btb_tag_q[lk_btb_idx];
    assign lk_entry.target = btb_tgt_q[lk_btb_idx];
    assign btb_hit         = lk_entry.valid && (lk_entry.tag == PC_current);

    // Counter MSB set means the counter is in the taken half.
    assign Prediction = btb_hit && lk_cnt[CNT_W-1];
    assign PCPredict  = Prediction ? lk_entry.target : PC_current + 32'd4;

    assign Mispredict = Branch && ((PredictedE != BranchTaken) ||
                        (PredictedE && BranchTaken && (PredTargetE != PCBranch)));
    assign PCCorrect  = BranchTaken ? PCBranch : PC + 32'd4;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++)
                btb_vld_q[i] <= 1'b0;
        end else if (btb_wr) begin
            btb_vld_q[up_btb_idx] <= 1'b1;
        end
    end

    // Tag/target are only observed through a valid bit, so they carry no reset.
    always_ff @(posedge Clk) begin
        if (btb_wr) begin
            btb_tag_q[up_btb_idx] <= PC;
            btb_tgt_q[up_btb_idx] <= PCBranch;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst)
            MispredCount <= '0;
        else if (Mispredict && MispredCount != 32'hFFFF_FFFF)
            MispredCount <= MispredCount + 32'd1;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter BTB_ENTRIES, default 32: BTB depth, a power of two of at least 2.
REQ-002 The block SHALL have parameter BHT_ENTRIES, default 128: BHT depth, a power of two of at least 2.
REQ-003 The block SHALL have parameter CNT_W, default 2: saturating-counter width, 1 to 4.
REQ-004 The block SHALL have parameter GHR_W, default 7: global history width, at most log2(BHT_ENTRIES); used only with GSHARE_EN.
REQ-005 The block SHALL have these ports:
- Clk  in  1  one clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- PC_current  in  32  fetch-stage PC (lookup).
- PC  in  32  execute-stage PC of the resolving instruction.
- PCBranch  in  32  computed branch target (execute).
- Branch  in  1  execute holds a conditional branch this cycle.
- BranchTaken  in  1  resolved outcome, valid when Branch=1.
- PredictedE  in  1  Prediction value carried down the pipeline with this branch.
- PredTargetE  in  32  PCPredict value carried down the pipeline with this branch.
- PCPredict  out  32  next fetch PC.
- Prediction  out  1  1 = predicted taken.
- Mispredict  out  1  execute-stage redirect request.
- PCCorrect  out  32  redirect address.
- MispredCount  out  32  performance counter.

Function
REQ-006 Lookup SHALL be combinational from PC_current, with zero-cycle latency.
- BTB index = PC_current[log2(BTB_ENTRIES)+1:2].
- BTB hit = entry valid and stored full 32-bit PC equals PC_current.
REQ-007 The BHT index SHALL be PC[log2(BHT_ENTRIES)+1:2], taken from PC_current for lookup and from PC for update.
REQ-008 Prediction SHALL be 1 when the BTB hits and the indexed counter is at least 2^(CNT_W-1).
- Prediction=1: PCPredict = stored target.
- Otherwise: Prediction=0 and PCPredict = PC_current+4, modulo 2^32.
REQ-009 On a rising edge with Branch=1, the indexed BHT counter SHALL update as a saturating counter:
- +1 if BranchTaken=1, held at 2^CNT_W-1;
- -1 if BranchTaken=0, held at 0.
REQ-010 On a rising edge with Branch=1 and BranchTaken=1, the BTB entry at PC's index SHALL be written with valid=1, tag=PC, target=PCBranch, overwriting any prior occupant.
REQ-011 A not-taken branch SHALL NOT modify the BTB.
REQ-012 Mispredict SHALL be combinational: Branch AND ((PredictedE != BranchTaken) OR (PredictedE AND BranchTaken AND PredTargetE != PCBranch)).
REQ-013 PCCorrect SHALL be PCBranch when BranchTaken=1, else PC+4.
REQ-014 PCCorrect's value SHALL be meaningful only while Mispredict=1.
REQ-015 MispredCount SHALL increment by 1 on each rising edge with Mispredict=1 and saturate at 32'hFFFFFFFF.
REQ-016 When a lookup and an update hit the same BTB/BHT index in the same cycle, the lookup SHALL see the pre-update contents (no bypass).
REQ-017 Branch=0 cycles SHALL leave all state unchanged except as REQ-015 allows.

Reset
REQ-018 While Rst=0, all of the following SHALL be cleared immediately, independent of Clk:
- all BTB valid bits;
- all BHT counters to 0 (strongly not taken);
- MispredCount;
- the GHR, when present.
REQ-019 During and directly after reset, Prediction SHALL be 0 and PCPredict = PC_current+4.
REQ-020 An update edge coincident with reset assertion SHALL be discarded.
REQ-021 Tag and target storage SHALL need no reset.

Configuration
REQ-022 With GSHARE_EN defined:
- a GHR_W-bit global history register SHALL shift left on each Branch=1 edge, with BranchTaken shifted into bit 0;
- the BHT index SHALL be the REQ-007 index XOR zero-extended GHR;
- lookup SHALL use the current GHR and update SHALL use the GHR value before its own shift.
REQ-023 Without GSHARE_EN, no GHR SHALL exist and REQ-007 indexing SHALL apply unchanged.

Structure
REQ-024 A shared package bp_pkg SHALL hold:
- the counter-state constants (STRONG_NT=0, WEAK_NT, WEAK_T, STRONG_T for CNT_W=2);
- the BTB entry typedef (valid, tag[31:0], target[31:0]);
- the default parameter values.
REQ-025 The saturating counter table SHALL be a sub-module bp_counter_table (read port, write port, async clear), instantiated once.

Verification
REQ-026 Scenario, cold branch:
- Stimulus: after reset, PC_current=0x40.
- Response: Prediction=0, PCPredict=0x44.
REQ-027 Scenario, counter training:
- Stimulus: two taken resolutions of PC=0x40, PCBranch=0x100, then PC_current=0x40.
- Response: Prediction=1, PCPredict=0x100, MispredCount=2 (both resolutions carried PredictedE=0).
REQ-028 Scenario, saturation and untraining:
- Stimulus: four taken resolutions of 0x40, then one not-taken.
- Response: counter is 3 then 2, and the branch is still predicted taken.
- Stimulus: one further not-taken.
- Response: counter is 1 and Prediction=0.
REQ-029 Scenario, target mismatch:
- Stimulus: Branch=1, BranchTaken=1, PredictedE=1, PredTargetE=0x100, PCBranch=0x200.
- Response: Mispredict=1, PCCorrect=0x200.
REQ-030 Scenario, aliasing:
- Stimulus: with BTB_ENTRIES=32, train 0x40 taken, then train 0xC0 taken.
- Response: PC_current=0x40 misses the BTB tag and PCPredict=0x44.
REQ-031 Scenario, reset mid-operation:
- Stimulus: assert Rst=0 between clock edges after training.
- Response: Prediction=0 immediately and MispredCount=0.
- Additionally, with GSHARE_EN: GHR=0.
